// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration scheduler: FSM states,
// requester ids, arbitration modes and the WM8731 device address.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/cfg_rr_arbiter.sv
// Two-way request arbiter: fixed priority (req0 wins) or round-robin, where the
// tie-break pointer flips on every grant and a lone requester always wins.
module cfg_rr_arbiter
  import codec_cfg_pkg::*;
#(
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    req0_valid,
  input  logic    req1_valid,
  input  logic    advance,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t rr_ptr;

  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = REQ0;
    if (ARB_MODE == ARB_RR) begin
      if (req0_valid && req1_valid) begin
        grant_id = rr_ptr;
      end else if (req1_valid) begin
        grant_id = REQ1;
      end
    end else begin
      if (!req0_valid && req1_valid) begin
        grant_id = REQ1;
      end
    end
  end

  // Pointer only moves when a grant is actually taken by the scheduler.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= REQ0;
    end else if ((ARB_MODE == ARB_RR) && advance) begin
      rr_ptr <= (rr_ptr == REQ0) ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/codec_cfg_scheduler.sv
// Shares one I2C write engine between the init sequencer (req0) and runtime control (req1).
// Optional WAIT watchdog and sticky o_err enabled by defining CODEC_CFG_TIMEOUT_EN.
module codec_cfg_scheduler
  import codec_cfg_pkg::*;
#(
  parameter int DATA_W         = 24,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ack,
  output logic              o_req0_done,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ack,
  output logic              o_req1_done,
  output logic [DATA_W-1:0] o_i2c_data,
  output logic              o_i2c_start,
  input  logic              i_i2c_finished,
  output logic              o_busy,
  output logic              o_err
);

  state_t      state;
  state_t      state_nxt;
  req_id_t     owner;
  logic        grant_valid;
  req_id_t     grant_id;
  logic        grant_take;
  logic        timeout_hit;

  cfg_rr_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .req0_valid  (i_req0_valid),
    .req1_valid  (i_req1_valid),
    .advance     (grant_take),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Reset is folded in so no ack can leak out while the block is held in reset.
  assign grant_take = (state == ST_IDLE) && grant_valid && i_rst_n;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (grant_take) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (i_i2c_finished || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      owner      <= REQ0;
      o_i2c_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        owner      <= grant_id;
        o_i2c_data <= (grant_id == REQ1) ? i_req1_data : i_req0_data;
      end
    end
  end

  assign o_req0_ack  = grant_take && (grant_id == REQ0);
  assign o_req1_ack  = grant_take && (grant_id == REQ1);
  assign o_req0_done = (state == ST_DONE) && (owner == REQ0);
  assign o_req1_done = (state == ST_DONE) && (owner == REQ1);
  assign o_i2c_start = (state == ST_START);
  assign o_busy      = (state != ST_IDLE);

`ifdef CODEC_CFG_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // A finished pulse on the limit cycle wins over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !i_i2c_finished && (wait_cnt == CNT_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == ST_WAIT) && (state_nxt == ST_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Self-checking bench: one fixed-priority and one round-robin scheduler driven with
// directed and random transactions against a transaction-level reference model.
`timescale 1ns/1ps
module tb_codec_cfg_scheduler;
  import codec_cfg_pkg::*;

  localparam int DW  = 24;
  localparam int TMO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          req0_valid   [2];
  logic [DW-1:0] req0_data    [2];
  logic          req0_ack     [2];
  logic          req0_done    [2];
  logic          req1_valid   [2];
  logic [DW-1:0] req1_data    [2];
  logic          req1_ack     [2];
  logic          req1_done    [2];
  logic [DW-1:0] i2c_data     [2];
  logic          i2c_start    [2];
  logic          i2c_finished [2];
  logic          busy         [2];
  logic          err          [2];

  int            checks   = 0;
  int            failures = 0;
  // Reference model state: unit 0 is fixed priority, unit 1 is round-robin.
  int            rr_next   [2];
  logic          err_exp   [2];
  logic [DW-1:0] last_word [2];

  always #5 i_clk = ~i_clk;

  codec_cfg_scheduler #(.DATA_W(DW), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(TMO)) dut_fixed (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(req0_valid[0]), .i_req0_data(req0_data[0]),
    .o_req0_ack(req0_ack[0]), .o_req0_done(req0_done[0]),
    .i_req1_valid(req1_valid[0]), .i_req1_data(req1_data[0]),
    .o_req1_ack(req1_ack[0]), .o_req1_done(req1_done[0]),
    .o_i2c_data(i2c_data[0]), .o_i2c_start(i2c_start[0]),
    .i_i2c_finished(i2c_finished[0]), .o_busy(busy[0]), .o_err(err[0])
  );

  codec_cfg_scheduler #(.DATA_W(DW), .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(TMO)) dut_rr (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(req0_valid[1]), .i_req0_data(req0_data[1]),
    .o_req0_ack(req0_ack[1]), .o_req0_done(req0_done[1]),
    .i_req1_valid(req1_valid[1]), .i_req1_data(req1_data[1]),
    .o_req1_ack(req1_ack[1]), .o_req1_done(req1_done[1]),
    .o_i2c_data(i2c_data[1]), .o_i2c_start(i2c_start[1]),
    .i_i2c_finished(i2c_finished[1]), .o_busy(busy[1]), .o_err(err[1])
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish within 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input int u, input string tag, input logic a0, input logic a1,
                          input logic st, input logic d0, input logic d1, input logic b);
    checkOutput($sformatf("u%0d %s ack0", u, tag), 32'(req0_ack[u]), 32'(a0));
    checkOutput($sformatf("u%0d %s ack1", u, tag), 32'(req1_ack[u]), 32'(a1));
    checkOutput($sformatf("u%0d %s start", u, tag), 32'(i2c_start[u]), 32'(st));
    checkOutput($sformatf("u%0d %s done0", u, tag), 32'(req0_done[u]), 32'(d0));
    checkOutput($sformatf("u%0d %s done1", u, tag), 32'(req1_done[u]), 32'(d1));
    checkOutput($sformatf("u%0d %s busy", u, tag), 32'(busy[u]), 32'(b));
    checkOutput($sformatf("u%0d %s err", u, tag), 32'(err[u]), 32'(err_exp[u]));
  endtask

  task automatic applyStimulus(input int u, input logic v0, input logic [DW-1:0] d0,
                               input logic v1, input logic [DW-1:0] d1, input logic fin);
    req0_valid[u]   = v0;
    req0_data[u]    = d0;
    req1_valid[u]   = v1;
    req1_data[u]    = d1;
    i2c_finished[u] = fin;
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleCheck(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      checkAll(u, "idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("u%0d idle data", u), 32'(i2c_data[u]), 32'(last_word[u]));
      nextCycle();
    end
  endtask

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      rr_next[u]   = 0;
      err_exp[u]   = 1'b0;
      last_word[u] = '0;
    end
  endtask

  // One full transaction, called at posedge+1 with the unit idle; the winner's valid
  // is dropped after its ack, the loser's valid is left as given.
  task automatic runTxn(input int u, input logic v0, input logic [DW-1:0] d0,
                        input logic v1, input logic [DW-1:0] d1,
                        input int nwait, input logic fin_in_start);
    int            w;
    logic [DW-1:0] word;
    if (v0 && v1) w = (u == 1) ? rr_next[u] : 0;
    else          w = v0 ? 0 : 1;
    if (u == 1) rr_next[u] = 1 - rr_next[u];
    word = (w == 1) ? d1 : d0;

    applyStimulus(u, v0, d0, v1, d1, 1'b0);
    @(negedge i_clk);
    checkAll(u, "ack", w == 0, w == 1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    if (w == 0) req0_valid[u] = 1'b0;
    else        req1_valid[u] = 1'b0;
    @(negedge i_clk);
    checkAll(u, "load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput($sformatf("u%0d load data", u), 32'(i2c_data[u]), 32'(word));
    nextCycle();
    i2c_finished[u] = fin_in_start;
    @(negedge i_clk);
    checkAll(u, "start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    i2c_finished[u] = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      @(negedge i_clk);
      checkAll(u, "wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
    end
    i2c_finished[u] = 1'b1;
    @(negedge i_clk);
    checkAll(u, "finish", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    i2c_finished[u] = 1'b0;
    @(negedge i_clk);
    checkAll(u, "done", 1'b0, 1'b0, 1'b0, w == 0, w == 1, 1'b1);
    checkOutput($sformatf("u%0d done data", u), 32'(i2c_data[u]), 32'(word));
    nextCycle();
    last_word[u] = word;
  endtask

  initial begin
    logic          v0;
    logic          v1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;

    i_rst_n = 1'b0;
    modelReset();
    for (int u = 0; u < 2; u++) applyStimulus(u, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    for (int u = 0; u < 2; u++) begin
      checkAll(u, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("u%0d reset data", u), 32'(i2c_data[u]), 32'h0);
    end
    nextCycle();
    i_rst_n = 1'b1;

    $display("[TB] req0 alone");
    runTxn(0, 1'b1, 24'h341E00, 1'b0, 24'h0, 3, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);
    idleCheck(0, 2);

    $display("[TB] fixed priority tie");
    runTxn(0, 1'b1, 24'h341200, 1'b1, 24'h340579, 2, 1'b0);
    runTxn(0, 1'b0, 24'h0, 1'b1, 24'h340579, 1, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);
    idleCheck(0, 1);

    $display("[TB] round-robin alternation");
    for (int k = 0; k < 4; k++) begin
      runTxn(1, 1'b1, DW'(24'h340A00 + k), 1'b1, DW'(24'h340B00 + k), 1, 1'b0);
    end
    applyStimulus(1, 1'b0, '0, 1'b0, '0, 1'b0);
    idleCheck(1, 1);

    $display("[TB] finished outside WAIT");
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge i_clk);
    checkAll(0, "fin_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    i2c_finished[0] = 1'b0;
    idleCheck(0, 1);
    runTxn(0, 1'b1, 24'h340C00, 1'b0, 24'h0, 2, 1'b1);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);

    $display("[TB] finished on the watchdog limit cycle");
    runTxn(0, 1'b1, 24'h340E02, 1'b0, 24'h0, TMO - 1, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);
    idleCheck(0, 1);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 1'b1, 24'h340C10, 1'b0, '0, 1'b0);
    @(negedge i_clk);
    checkAll(0, "pre_rst_ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    req0_valid[0] = 1'b0;
    repeat (3) nextCycle();
    i_rst_n = 1'b0;
    req0_valid[0] = 1'b1;
    modelReset();
    @(negedge i_clk);
    for (int u = 0; u < 2; u++) begin
      checkAll(u, "mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("u%0d mid_rst data", u), 32'(i2c_data[u]), 32'h0);
    end
    nextCycle();
    i_rst_n = 1'b1;
    req0_valid[0] = 1'b0;
    idleCheck(0, 3);
    runTxn(0, 1'b1, 24'h340E01, 1'b0, 24'h0, 2, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);

`ifdef CODEC_CFG_TIMEOUT_EN
    $display("[TB] WAIT watchdog");
    applyStimulus(0, 1'b1, 24'h341234, 1'b0, '0, 1'b0);
    @(negedge i_clk);
    checkAll(0, "tmo_ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    req0_valid[0] = 1'b0;
    @(negedge i_clk);
    checkAll(0, "tmo_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    @(negedge i_clk);
    checkAll(0, "tmo_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    for (int i = 0; i < TMO; i++) begin
      @(negedge i_clk);
      checkAll(0, "tmo_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
    end
    err_exp[0] = 1'b1;
    @(negedge i_clk);
    checkAll(0, "tmo_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    last_word[0] = 24'h341234;
    idleCheck(0, 2);
    runTxn(0, 1'b1, 24'h345678, 1'b0, 24'h0, 1, 1'b0);
    applyStimulus(0, 1'b0, '0, 1'b0, '0, 1'b0);
    i_rst_n = 1'b0;
    modelReset();
    @(negedge i_clk);
    checkAll(0, "tmo_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    i_rst_n = 1'b1;
`endif

    $display("[TB] random transactions");
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 16; k++) begin
        v0 = 1'($urandom_range(0, 1));
        v1 = 1'($urandom_range(0, 1));
        if (!v0 && !v1) v1 = 1'b1;
        d0 = DW'($urandom);
        d1 = DW'($urandom);
        runTxn(u, v0, d0, v1, d1, int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
      end
      applyStimulus(u, 1'b0, '0, 1'b0, '0, 1'b0);
      idleCheck(u, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
